mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one unified memory port between the CPU's instruction-fetch channel and its data-access channel. It sits between `custom_cpu` and the memory/bus wrapper, so one single-ported memory can serve both fetch and load/store traffic. It allows one outstanding transaction at a time, arbitrates round-robin, and forwards the valid/ready handshakes on both sides without buffering payload.

## Interface
Parameters:
- none; widths fixed at 32-bit address/data and 4-bit strobe

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `PC`  in  32  fetch address from CPU
- `Inst_Req_Valid`  in  1  fetch request valid
- `Inst_Req_Ready`  out  1  fetch request accepted
- `Instruction`  out  32  fetched word
- `Inst_Valid`  out  1  fetch response valid
- `Inst_Ready`  in  1  CPU accepts fetch response
- `Address`  in  32  data address
- `MemWrite`  in  1  data write request
- `MemRead`  in  1  data read request
- `Write_data`  in  32  store data
- `Write_strb`  in  4  store byte strobes
- `Mem_Req_Ready`  out  1  data request accepted
- `Read_data`  out  32  load data
- `Read_data_Valid`  out  1  load response valid
- `Read_data_Ready`  in  1  CPU accepts load response
- `mem_addr`  out  32  unified port address
- `mem_wen`  out  1  unified write
- `mem_ren`  out  1  unified read
- `mem_wdata`  out  32  unified write data
- `mem_wstrb`  out  4  unified strobes
- `mem_req_ready`  in  1  unified request accepted
- `mem_rdata`  in  32  unified response data
- `mem_rvalid`  in  1  unified response valid
- `mem_rready`  out  1  unified response accepted
- `conflict_cnt`  out  32  count of cycles in which a pending request waits while the port is busy or the other side holds the grant

## Operation
- FSM states: IDLE, I_REQ, I_RESP, D_REQ, D_RESP.
- IDLE:
  - Pending I-side request = `Inst_Req_Valid`; pending D-side request = `MemRead | MemWrite`.
  - With one pending side, grant that side. With both pending, grant the side opposite `last_grant`.
  - On grant, `last_grant` updates and the FSM moves to I_REQ or D_REQ.
- I_REQ:
  - Outputs: `mem_ren=1`, `mem_addr=PC`, `Inst_Req_Ready=mem_req_ready`.
  - On handshake, go to I_RESP.
- I_RESP:
  - Forwarding: `Instruction=mem_rdata`, `Inst_Valid=mem_rvalid`, `mem_rready=Inst_Ready`.
  - On `mem_rvalid & Inst_Ready`, go to IDLE.
- D_REQ:
  - Outputs: `mem_addr=Address`, `mem_wen=MemWrite`, `mem_ren=MemRead & ~MemWrite`, `mem_wdata`/`mem_wstrb` passed through, `Mem_Req_Ready=mem_req_ready`.
  - On handshake, a write goes to IDLE (writes have no response); a read goes to D_RESP.
- D_RESP: forwards `Read_data`, `Read_data_Valid`, and `mem_rready` as in I_RESP; on response handshake, go to IDLE.
- `MemRead` and `MemWrite` asserted together is illegal upstream; the arbiter treats it as a write.
- Upstream must hold its request valid and payload stable until ready. The arbiter registers no payload; address and data are combinational muxes selected by state.
- Outside its owning state, every handshake output is 0 and every data output is 0.
- `conflict_cnt` increments by 1 per qualifying cycle, wraps at 2^32-1 → 0, and is never cleared except by reset.

## Timing
- Reset (asynchronous, effective immediately):
  - state=IDLE, `last_grant`=D (so the first simultaneous contest goes to I), `conflict_cnt`=0.
  - All valid/ready/wen/ren outputs are 0; all data outputs are 0.
- Arbitration costs one bubble cycle: a request first seen in IDLE at cycle N drives the unified port at cycle N+1. The earliest request handshake is at N+1.
- Read round trip through the arbiter is 1 cycle plus the downstream latency. A request is accepted in the same cycle as `mem_req_ready`, and a response is consumed in the same cycle as the handshake.
- Back-to-back transactions always pass through IDLE, so there is at least one idle cycle between grants.
- A requester that drops valid before the handshake violates protocol; the arbiter stays in REQ until the handshake completes.
- Reset mid-transaction aborts the transaction. The downstream memory shares `rst`, so no stale response is expected.

## Structure
- Shared package `mem_arb_pkg`: FSM state encoding (3-bit), grant constants GRANT_I=0 and GRANT_D=1.
- Single flat module, no sub-modules. `conflict_cnt` is an inline counter.

## Test plan
- Fetch only: `PC=0x0000_0010`, memory ready after 2 cycles, `mem_rdata=0x0000_0013` → `Inst_Valid=1` with `Instruction=0x0000_0013`; `mem_ren=1` and `mem_wen=0` throughout.
- Simultaneous fetch and load from reset: fetch and load requests together → I is granted first and D second; on the next contest, I is granted again; `conflict_cnt` increments on every waiting cycle.
- Store: `Address=0x100`, `Write_data=0xDEADBEEF`, `Write_strb=0xF` → one `mem_wen` handshake, then return to IDLE with no `Read_data_Valid`.
- Backpressure: `Read_data_Ready=0` for 5 cycles while `mem_rvalid=1` → `mem_rready=0` and data held until accept.
- Reset asserted in D_RESP → all outputs 0 in the same cycle and `conflict_cnt=0`; a fetch after release is granted first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM encoding and grant ids.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_REQ  = 3'd1,
        I_RESP = 3'd2,
        D_REQ  = 3'd3,
        D_RESP = 3'd4
    } arb_state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and data channels, round-robin, one transaction in flight.
// Latency: one arbitration bubble in IDLE, then request/response handshakes forwarded combinationally.
// Backpressure: ready/valid passed straight through to the owning side; no payload is buffered.
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    // instruction-fetch channel
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ready,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    // data channel
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready,
    // unified memory port
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_req_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    // statistics
    output logic [31:0] conflict_cnt
);

    arb_state_t  state_q;
    logic        last_grant_q;
    logic [31:0] conflict_cnt_q;
    logic [31:0] conflict_cnt_d;

    logic i_pend;
    logic d_pend;
    logic grant_side;
    logic i_wait;
    logic d_wait;

    assign i_pend = Inst_Req_Valid;
    assign d_pend = MemRead | MemWrite;

    // Round-robin pick: a lone requester wins; a contest goes to the side that did not win last.
    always_comb begin
        grant_side = GRANT_I;
        if (i_pend && d_pend) begin
            grant_side = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_pend) begin
            grant_side = GRANT_D;
        end
    end

    // A side is waiting when it has a request up but is neither being granted nor driving the request phase.
    always_comb begin
        i_wait = 1'b0;
        d_wait = 1'b0;
        case (state_q)
            IDLE: begin
                i_wait = i_pend && (grant_side == GRANT_D);
                d_wait = d_pend && (grant_side == GRANT_I);
            end
            I_REQ:   d_wait = d_pend;
            D_REQ:   i_wait = i_pend;
            default: begin
                i_wait = i_pend;
                d_wait = d_pend;
            end
        endcase
    end

    assign conflict_cnt_d = conflict_cnt_q + 32'd1;

    // Arbitration FSM: grant from IDLE, hold the port until the request and (for reads) the response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_pend || d_pend) begin
                        last_grant_q <= grant_side;
                        state_q      <= (grant_side == GRANT_I) ? I_REQ : D_REQ;
                    end
                end
                I_REQ: begin
                    if (mem_req_ready) begin
                        state_q <= I_RESP;
                    end
                end
                I_RESP: begin
                    if (mem_rvalid && Inst_Ready) begin
                        state_q <= IDLE;
                    end
                end
                D_REQ: begin
                    // Writes carry no response, so they release the port at the request handshake.
                    if (mem_req_ready && d_pend) begin
                        state_q <= MemWrite ? IDLE : D_RESP;
                    end
                end
                D_RESP: begin
                    if (mem_rvalid && Read_data_Ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Free-running contention counter, wraps naturally and clears only on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_q <= 32'd0;
        end else if (i_wait || d_wait) begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;

    // Steer the unified port and the handshakes by state; everything outside the owning state stays 0.
    always_comb begin
        Inst_Req_Ready  = 1'b0;
        Instruction     = 32'd0;
        Inst_Valid      = 1'b0;
        Mem_Req_Ready   = 1'b0;
        Read_data       = 32'd0;
        Read_data_Valid = 1'b0;
        mem_addr        = 32'd0;
        mem_wen         = 1'b0;
        mem_ren         = 1'b0;
        mem_wdata       = 32'd0;
        mem_wstrb       = 4'd0;
        mem_rready      = 1'b0;
        if (!rst) begin
            case (state_q)
                I_REQ: begin
                    mem_ren        = 1'b1;
                    mem_addr       = PC;
                    Inst_Req_Ready = mem_req_ready;
                end
                I_RESP: begin
                    Instruction = mem_rdata;
                    Inst_Valid  = mem_rvalid;
                    mem_rready  = Inst_Ready;
                end
                D_REQ: begin
                    // Read and write together is treated as a write.
                    mem_addr      = Address;
                    mem_wen       = MemWrite;
                    mem_ren       = MemRead & ~MemWrite;
                    mem_wdata     = Write_data;
                    mem_wstrb     = Write_strb;
                    Mem_Req_Ready = mem_req_ready;
                end
                D_RESP: begin
                    Read_data       = mem_rdata;
                    Read_data_Valid = mem_rvalid;
                    mem_rready      = Read_data_Ready;
                end
                default: ;
            endcase
        end
    end

endmodule
